// File: rtl/vm_rsp_collector.sv
// vm_rsp_collector: reassembles the VM 6-beat response burst into one registered record and flags protocol errors.
// Optional VM_COLLECT_STATS_EN adds saturating transaction/error counters.
module vm_rsp_collector #(
    parameter int NUM_BEATS = 6,
    parameter int MON_W     = 9,
    parameter int SELL_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vm_valid,
    input  logic [3:0]            vm_consumer,
    input  logic [SELL_W-1:0]     vm_sell_num,
    input  logic [MON_W-1:0]      vm_monitor,
    output logic                  rec_valid,
    output logic [2:0]            rec_item,
    output logic [19:0]           rec_coins,
    output logic [9:0]            rec_change,
    output logic [6*SELL_W-1:0]   rec_sell,
    output logic [MON_W-1:0]      rec_balance,
    output logic                  err_short,
    output logic                  err_long,
    output logic                  err_mismatch
`ifdef VM_COLLECT_STATS_EN
    ,
    output logic [15:0]           stat_txn,
    output logic [7:0]            stat_err
`endif
);
    typedef enum logic [1:0] {IDLE, CAPT, DONE, DRAIN} state_t;
    localparam logic [2:0] LAST = 3'(NUM_BEATS - 1);
    state_t state, state_n;
    logic [2:0] beat;
    logic [MON_W-1:0] shadow;
    logic [2:0] item_r;
    logic [15:0] coins_r;
    logic [5*SELL_W-1:0] sell_r;
    logic [9:0] acc, acc_n;
    logic [5:0] weight;
    logic [10:0] sum;
    assign weight = beat == 3'd1 ? 6'd50 : beat == 3'd2 ? 6'd20 : beat == 3'd3 ? 6'd10 :
                    beat == 3'd4 ? 6'd5 : 6'd1;
    assign sum    = 11'(acc) + 11'(vm_consumer) * 11'(weight);
    assign acc_n  = sum > 11'd1023 ? 10'd1023 : sum[9:0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n   = state;
        rec_valid = 1'b0;
        err_long  = 1'b0;
        case (state)
            IDLE:  state_n = vm_valid ? CAPT : IDLE;
            CAPT:  state_n = !vm_valid ? IDLE : beat == LAST ? DONE : CAPT;
            DONE: begin
                rec_valid = 1'b1;
                err_long  = vm_valid;
                state_n   = vm_valid ? DRAIN : IDLE;
            end
            DRAIN: state_n = vm_valid ? DRAIN : IDLE;
            default: state_n = IDLE;
        endcase
    end
    // Coins and sell counts shift in beat by beat, so the final beat completes the record directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat         <= '0;
            shadow       <= '0;
            item_r       <= '0;
            coins_r      <= '0;
            sell_r       <= '0;
            acc          <= '0;
            rec_item     <= '0;
            rec_coins    <= '0;
            rec_change   <= '0;
            rec_sell     <= '0;
            rec_balance  <= '0;
            err_short    <= 1'b0;
            err_mismatch <= 1'b0;
        end else begin
            err_short    <= state == CAPT && !vm_valid;
            err_mismatch <= 1'b0;
            if (!vm_valid) shadow <= vm_monitor;
            if (state == IDLE && vm_valid) begin
                item_r <= vm_consumer[2:0];
                beat   <= 3'd1;
                acc    <= '0;
                sell_r <= {vm_sell_num, sell_r[5*SELL_W-1:SELL_W]};
            end
            if (state == CAPT && !vm_valid) beat <= '0;
            if (state == CAPT && vm_valid) begin
                beat    <= beat + 3'd1;
                acc     <= acc_n;
                coins_r <= {coins_r[11:0], vm_consumer};
                sell_r  <= {vm_sell_num, sell_r[5*SELL_W-1:SELL_W]};
                if (beat == LAST) begin
                    beat         <= '0;
                    rec_item     <= item_r;
                    rec_coins    <= {coins_r, vm_consumer};
                    rec_change   <= acc_n;
                    rec_sell     <= {vm_sell_num, sell_r};
                    rec_balance  <= shadow;
                    err_mismatch <= item_r == 3'd0 && acc_n != 10'(shadow);
                end
            end
        end
    end
`ifdef VM_COLLECT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_txn <= '0;
            stat_err <= '0;
        end else begin
            if (rec_valid && stat_txn != 16'hFFFF) stat_txn <= stat_txn + 16'd1;
            if ((err_short || err_long || err_mismatch) && stat_err != 8'hFF) stat_err <= stat_err + 8'd1;
        end
    end
`endif
endmodule
